// File: rtl/pipeline_pkg.sv
// Shared encodings for the 5-stage pipeline hazard logic: opcode/aluop
// constants, instruction field positions and the multdiv sequencer states.
package pipeline_pkg;

    localparam logic [4:0] OP_R    = 5'b00000;
    localparam logic [4:0] OP_ADDI = 5'b00101;
    localparam logic [4:0] OP_LW   = 5'b01000;
    localparam logic [4:0] OP_SW   = 5'b00111;
    localparam logic [4:0] OP_BNE  = 5'b00010;
    localparam logic [4:0] OP_BLT  = 5'b00110;
    localparam logic [4:0] OP_JR   = 5'b00100;

    localparam logic [4:0] ALU_MUL = 5'b00110;
    localparam logic [4:0] ALU_DIV = 5'b00111;

    localparam int OPC_HI = 31;
    localparam int OPC_LO = 27;
    localparam int RD_HI  = 26;
    localparam int RD_LO  = 22;
    localparam int RS_HI  = 21;
    localparam int RS_LO  = 17;
    localparam int RT_HI  = 16;
    localparam int RT_LO  = 12;
    localparam int ALU_HI = 6;
    localparam int ALU_LO = 2;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } md_state_t;

endpackage

// File: rtl/src_decode.sv
// Extracts the register sources and hazard-relevant attributes of one
// instruction; unused source slots read as register 0.
module src_decode
    import pipeline_pkg::*;
(
    input  logic [31:0] ir,
    output logic [4:0]  src1,
    output logic [4:0]  src2,
    output logic [4:0]  rd,
    output logic        is_lw,
    output logic        is_md,
    output logic        md_op
);

    logic [4:0] opcode;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] aluop;

    assign opcode = ir[OPC_HI:OPC_LO];
    assign rd     = ir[RD_HI:RD_LO];
    assign rs     = ir[RS_HI:RS_LO];
    assign rt     = ir[RT_HI:RT_LO];
    assign aluop  = ir[ALU_HI:ALU_LO];

    always_comb begin
        src1 = 5'd0;
        src2 = 5'd0;
        case (opcode)
            OP_R: begin
                src1 = rs;
                src2 = rt;
            end
            OP_ADDI, OP_LW: src1 = rs;
            // Stores and branches read rd as a data/compare source.
            OP_SW, OP_BNE, OP_BLT: begin
                src1 = rd;
                src2 = rs;
            end
            OP_JR: src1 = rd;
            default: begin
                src1 = 5'd0;
                src2 = 5'd0;
            end
        endcase
    end

    assign is_lw = (opcode == OP_LW);
    assign is_md = (opcode == OP_R) && ((aluop == ALU_MUL) || (aluop == ALU_DIV));
    assign md_op = aluop[0];

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Stall/bubble sequencer: load-use detection between decode and execute plus
// the multdiv start/wait/release state machine with a timeout guard.
module pipeline_stall_ctrl
    import pipeline_pkg::*;
#(
    parameter int MD_TIMEOUT = 40
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [31:0] decodeIR,
    input  logic [31:0] executeIR,
    input  logic        md_ready,
    input  logic        md_exception,
    output logic        stall_fd,
    output logic        bubble_dx,
    output logic        stall_dx,
    output logic        bubble_xm,
    output logic        md_start,
    output logic        md_op,
    output logic        md_exc,
    output logic        md_timeout,
    output logic        dbg_state
);

    localparam int CNT_W = $clog2(MD_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MD_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MD_TIMEOUT);

    logic [4:0] dec_src1, dec_src2, dec_rd;
    logic       dec_is_lw, dec_is_md, dec_md_op;
    logic [4:0] ex_src1, ex_src2, ex_rd;
    logic       ex_is_lw, ex_is_md, ex_md_op;

    src_decode u_dec (
        .ir    (decodeIR),
        .src1  (dec_src1),
        .src2  (dec_src2),
        .rd    (dec_rd),
        .is_lw (dec_is_lw),
        .is_md (dec_is_md),
        .md_op (dec_md_op)
    );

    src_decode u_ex (
        .ir    (executeIR),
        .src1  (ex_src1),
        .src2  (ex_src2),
        .rd    (ex_rd),
        .is_lw (ex_is_lw),
        .is_md (ex_is_md),
        .md_op (ex_md_op)
    );

    md_state_t        state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             timeout_q;
    logic             timeout_set;
    logic             md_stall;
    logic             start;
    logic             exc;
    logic             load_use;

    // ex_rd is nonzero, so a zero source slot can never produce a match.
    assign load_use = ex_is_lw && (ex_rd != 5'd0) &&
                      ((dec_src1 == ex_rd) || (dec_src2 == ex_rd));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            cnt       <= '0;
            timeout_q <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (timeout_set) timeout_q <= 1'b1;
        end
    end

    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        timeout_set = 1'b0;
        md_stall    = 1'b0;
        start       = 1'b0;
        exc         = 1'b0;
        case (state)
            IDLE: begin
                if (ex_is_md) begin
                    start      = 1'b1;
                    md_stall   = 1'b1;
                    cnt_next   = '0;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (md_ready) begin
                    exc        = md_exception;
                    cnt_next   = '0;
                    state_next = IDLE;
                end else if (cnt == CNT_LAST) begin
                    timeout_set = 1'b1;
                    cnt_next    = '0;
                    state_next  = IDLE;
                end else begin
                    md_stall = 1'b1;
                    cnt_next = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Every output is forced low while reset_n is asserted.
    assign stall_fd   = reset_n & (md_stall | load_use);
    assign bubble_dx  = reset_n & load_use & ~md_stall;
    assign stall_dx   = reset_n & md_stall;
    assign bubble_xm  = reset_n & md_stall;
    assign md_start   = reset_n & start;
    assign md_op      = reset_n & start & ex_md_op;
    assign md_exc     = reset_n & exc;
    assign md_timeout = reset_n & timeout_q;
    assign dbg_state  = reset_n & (state == WAIT);

endmodule
